// File: rtl/mips_pipe_pkg.sv
// Shared definitions for MIPS pipeline stage registers: reset constants,
// pc type and the occupancy encoding of a skid-buffered stage.
package mips_pipe_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;  // sll $0,$0,0

  typedef logic [PC_W_DEF-1:0] pc_t;

  // Encoding is {S.v, M.v}; 2'b10 (skid live, main empty) must never occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_e;

  function automatic state_e decode_state(input logic m_v, input logic s_v);
    state_e st;
    case ({s_v, m_v})
      2'b00:   st = EMPTY;
      2'b01:   st = FULL;
      default: st = SKID;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: valid bit plus {pc, payload}.
// load wins over clear; clear only drops the valid bit so pc is retained.
module pipe_slot
  import mips_pipe_pkg::*;
#(
  parameter int              PC_W   = 32,
  parameter int              DATA_W = 32,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   ld_pc,
  input  logic [DATA_W-1:0] ld_data,
  output logic              v,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data
);

  logic              v_q, v_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: load a new entry, or invalidate while keeping the old pc.
  always_comb begin
    v_d    = v_q;
    pc_d   = pc_q;
    data_d = data_q;
    if (load) begin
      v_d    = 1'b1;
      pc_d   = ld_pc;
      data_d = ld_data;
    end else if (clear) begin
      v_d    = 1'b0;
    end
  end

  // Slot register with synchronous reset to an empty slot at RST_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      pc_q   <= RST_PC;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      pc_q   <= pc_d;
      data_q <= data_d;
    end
  end

  assign v    = v_q;
  assign pc   = pc_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Generic valid/ready pipeline stage register with a one-entry skid slot.
// in_ready is a flop (== ~S.v) so a downstream stall never reaches the
// upstream PC logic combinationally. Outputs are taken only from the main slot.
module pipe_stage_skid_reg
  import mips_pipe_pkg::*;
#(
  parameter int                PC_W     = 32,
  parameter int                DATA_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEF),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc4,
  output logic [PC_W-1:0]   out_pc8,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_v, s_v;
  logic [PC_W-1:0]   m_pc, s_pc, m_ld_pc;
  logic [DATA_W-1:0] m_data, s_data, m_ld_data;
  logic              m_load, m_from_s, m_clear;
  logic              s_load, s_clear, s_v_nxt;
  logic              in_ready_q, in_ready_d;
  logic              accept, drain;
  logic [CNT_W-1:0]  bubble_q, bubble_d, stall_q, stall_d;
  state_e            state;

  assign state  = decode_state(m_v, s_v);
  assign accept = in_valid & in_ready_q;
  assign drain  = m_v & out_ready;

  // Occupancy control: decide which slot loads or empties this cycle.
  always_comb begin
    m_load   = 1'b0;
    m_from_s = 1'b0;
    m_clear  = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    case (state)
      EMPTY: m_load = accept;
      FULL: begin
        if (accept && drain)  m_load  = 1'b1;
        else if (accept)      s_load  = 1'b1;
        else if (drain)       m_clear = 1'b1;
      end
      SKID: begin
        // in_ready is low here, so only the skid entry can move forward.
        if (drain) begin
          m_load   = 1'b1;
          m_from_s = 1'b1;
          s_clear  = 1'b1;
        end
      end
      default: begin
        m_clear = 1'b1;
        s_clear = 1'b1;
      end
    endcase
    // Flush kills both slots and anything arriving this cycle.
    if (flush) begin
      m_load  = 1'b0;
      s_load  = 1'b0;
      m_clear = 1'b1;
      s_clear = 1'b1;
    end
  end

  assign m_ld_pc   = m_from_s ? s_pc   : in_pc;
  assign m_ld_data = m_from_s ? s_data : in_data;

  pipe_slot #(.PC_W(PC_W), .DATA_W(DATA_W), .RST_PC(RESET_PC)) u_main (
    .clk(clk), .reset(reset), .load(m_load), .clear(m_clear),
    .ld_pc(m_ld_pc), .ld_data(m_ld_data),
    .v(m_v), .pc(m_pc), .data(m_data)
  );

  pipe_slot #(.PC_W(PC_W), .DATA_W(DATA_W), .RST_PC(RESET_PC)) u_skid (
    .clk(clk), .reset(reset), .load(s_load), .clear(s_clear),
    .ld_pc(in_pc), .ld_data(in_data),
    .v(s_v), .pc(s_pc), .data(s_data)
  );

  // in_ready follows the skid slot's next valid so it can be a flop.
  always_comb begin
    s_v_nxt    = s_load ? 1'b1 : (s_clear ? 1'b0 : s_v);
    in_ready_d = ~s_v_nxt;
  end

  // Saturating performance counters; flush leaves them untouched.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (!m_v && (bubble_q != {CNT_W{1'b1}}))
      bubble_d = bubble_q + 1'b1;
    if (m_v && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // Registered ready and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q <= 1'b1;
      bubble_q   <= '0;
      stall_q    <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      bubble_q   <= bubble_d;
      stall_q    <= stall_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_v;
  assign out_pc     = m_pc;
  assign out_pc4    = m_pc + PC_W'(4);
  assign out_pc8    = m_pc + PC_W'(8);
  assign out_data   = m_v ? m_data : NOP_WORD;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg with a scoreboard queue of
// accepted {pc,data}; every drained entry is popped and compared.
module tb_pipe_stage_skid_reg;

  localparam int PC_W = 32, DATA_W = 32, CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0]   in_pc, out_pc, out_pc4, out_pc8;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  pipe_stage_skid_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8), .out_data(out_data),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dat(input logic [PC_W-1:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // One clock: score the drain/accept seen before the edge, then advance.
  task automatic tick();
    logic [63:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_out", {out_pc, out_data}, 64'h0);
      else begin
        e = sb.pop_front();
        chk("sb_pc", 64'(out_pc), 64'(e[63:32]));
        chk("sb_data", 64'(out_data), 64'(e[31:0]));
      end
    end
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back({in_pc, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_data  = dat(pc);
  endtask

  task automatic chk_reset_state(input string p);
    chk({p, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({p, "_in_ready"},  64'(in_ready),  64'd1);
    chk({p, "_out_pc"},    64'(out_pc),    64'h3000);
    chk({p, "_out_pc4"},   64'(out_pc4),   64'h3004);
    chk({p, "_out_pc8"},   64'(out_pc8),   64'h3008);
    chk({p, "_out_data"},  64'(out_data),  64'h0);
    chk({p, "_bubble"},    64'(bubble_cnt), 64'd0);
    chk({p, "_stall"},     64'(stall_cnt),  64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    @(posedge clk); #1;
    tick();
    reset = 1'b0;
    chk_reset_state("rst");

    // Streaming: three back-to-back entries, one cycle latency.
    out_ready = 1'b1;
    drive(1'b1, 32'h3000); tick();
    chk("stream_valid0", 64'(out_valid), 64'd1);
    chk("stream_pc0", 64'(out_pc), 64'h3000);
    drive(1'b1, 32'h3004); tick();
    chk("stream_pc1", 64'(out_pc), 64'h3004);
    drive(1'b1, 32'h3008); tick();
    chk("stream_pc2", 64'(out_pc), 64'h3008);
    drive(1'b0, 32'h0); tick();
    chk("stream_empty", 64'(out_valid), 64'd0);
    chk("stream_pc_hold", 64'(out_pc), 64'h3008);
    chk("stream_nop", 64'(out_data), 64'h0);
    chk("stream_bubble", 64'(bubble_cnt), 64'd1);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Stall: FULL(0x3010), downstream stalls while 0x3014 arrives -> SKID.
    drive(1'b1, 32'h3010); tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h3014); tick();
    chk("stall_skid_ready", 64'(in_ready), 64'd0);
    chk("stall_skid_pc", 64'(out_pc), 64'h3010);
    drive(1'b0, 32'h0); tick();
    chk("stall_hold_ready", 64'(in_ready), 64'd0);
    chk("stall_hold_pc", 64'(out_pc), 64'h3010);
    out_ready = 1'b1; tick();
    chk("stall_rel_pc", 64'(out_pc), 64'h3014);
    chk("stall_rel_ready", 64'(in_ready), 64'd1);
    tick();
    chk("stall_cnt", 64'(stall_cnt), 64'd2);
    chk("stall_bubble", 64'(bubble_cnt), 64'd2);
    chk("stall_drained", 64'(out_valid), 64'd0);

    // Flush while in SKID with a new entry offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h3020); tick();
    drive(1'b1, 32'h3024); tick();
    chk("flush_pre_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h3028); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", 64'(out_data), 64'h0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_pc_hold", 64'(out_pc), 64'h3020);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_nothing_out", 64'(out_valid), 64'd0);
    chk("flush_bubble", 64'(bubble_cnt), 64'd5);
    chk("flush_stall", 64'(stall_cnt), 64'd4);

    // Reset, flush and accept all in one cycle with a live entry.
    out_ready = 1'b0;
    drive(1'b1, 32'h3030); tick();
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h3034); tick();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0);
    chk_reset_state("rfa");

    // Bubble counter saturation at 2^CNT_W-1.
    for (int i = 0; i < 20; i++) tick();
    chk("sat_bubble", 64'(bubble_cnt), 64'd15);
    tick();
    chk("sat_bubble_hold", 64'(bubble_cnt), 64'd15);
    chk("sat_stall", 64'(stall_cnt), 64'd0);

    // pc wrap on the +4/+8 adders.
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFC); tick();
    drive(1'b0, 32'h0);
    chk("wrap_pc", 64'(out_pc), 64'hFFFF_FFFC);
    chk("wrap_pc4", 64'(out_pc4), 64'h0);
    chk("wrap_pc8", 64'(out_pc8), 64'h4);
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
